// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one fixed-latency single-port SRAM between the IF
// (instruction fetch) and MEM (load/store) pipeline stages. One access runs
// at a time, and MEM always wins over IF. The arbiter returns the data with a
// one-cycle valid/ready pulse and freezes a stage while its access is pending.
// A taken branch cancels an in-flight fetch.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        branch_taken,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        if_freeze,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_freeze,
  output logic        sram_en,
  output logic        sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BUSY_IF  = 3'd1,
    BUSY_MEM = 3'd2,
    DONE_IF  = 3'd3,
    DONE_MEM = 3'd4
  } state_t;

  // The counter starts at WAIT_CYCLES-1 so that it reaches zero in the last enable cycle.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] cnt_r;
  logic       we_r;
  logic       mem_req_s;
  logic       load_mem_s;
  logic       load_if_s;
  logic       cap_if_s;
  logic       cap_mem_s;
  logic       busy_s;

  // When both enables are high, the request is treated as a store because we_r follows mem_w_en.
  assign mem_req_s  = mem_r_en | mem_w_en;
  assign if_freeze  = if_req & ~if_valid;
  assign mem_freeze = mem_req_s & ~mem_ready;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: MEM has priority, a branch aborts a fetch, and loads/stores always run to completion.
  always_comb begin
    state_s    = state_r;
    load_mem_s = 1'b0;
    load_if_s  = 1'b0;
    cap_if_s   = 1'b0;
    cap_mem_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (mem_req_s) begin
          state_s    = BUSY_MEM;
          load_mem_s = 1'b1;
        end else if (if_req && !branch_taken) begin
          state_s   = BUSY_IF;
          load_if_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY_IF: begin
        if (branch_taken) begin
          state_s = IDLE;
        end else if (cnt_r == 4'd0) begin
          state_s  = DONE_IF;
          cap_if_s = 1'b1;
        end else begin
          state_s = BUSY_IF;
        end
      end
      BUSY_MEM: begin
        if (cnt_r == 4'd0) begin
          state_s   = DONE_MEM;
          cap_mem_s = ~we_r;
        end else begin
          state_s = BUSY_MEM;
        end
      end
      DONE_IF:  state_s = IDLE;
      DONE_MEM: state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // Output decode from the registered state; a same-cycle branch masks the fetch pulse.
  always_comb begin
    sram_en   = 1'b0;
    sram_we   = 1'b0;
    if_valid  = 1'b0;
    mem_ready = 1'b0;
    busy_s    = 1'b0;
    case (state_r)
      BUSY_IF: begin
        sram_en = 1'b1;
        busy_s  = 1'b1;
      end
      BUSY_MEM: begin
        sram_en = 1'b1;
        sram_we = we_r;
        busy_s  = 1'b1;
      end
      DONE_IF:  if_valid  = ~branch_taken;
      DONE_MEM: mem_ready = 1'b1;
      default: begin
        sram_en = 1'b0;
      end
    endcase
  end

  // Latch the address, data and write flag at acceptance, then count the access down.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= 4'd0;
      we_r       <= 1'b0;
      sram_addr  <= 32'd0;
      sram_wdata <= 32'd0;
    end else if (load_mem_s) begin
      cnt_r      <= CNT_LOAD;
      we_r       <= mem_w_en;
      sram_addr  <= mem_addr;
      sram_wdata <= mem_wdata;
    end else if (load_if_s) begin
      cnt_r     <= CNT_LOAD;
      we_r      <= 1'b0;
      sram_addr <= if_addr;
    end else if (busy_s && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Capture read data in the last enable cycle; the held value stays until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_instruction <= 32'd0;
      mem_rdata      <= 32'd0;
    end else begin
      if (cap_if_s) begin
        if_instruction <= sram_rdata;
      end
      if (cap_mem_s) begin
        mem_rdata <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed cycle-by-cycle vectors for sram_arbiter with
// WAIT_CYCLES=3. Inputs change 1 ns after each rising edge, and outputs are
// sampled 1 ns later.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        branch_taken;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic        if_freeze;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_freeze;
  logic        sram_en;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  sram_arbiter #(.WAIT_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .branch_taken(branch_taken),
    .if_instruction(if_instruction), .if_valid(if_valid), .if_freeze(if_freeze),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_freeze(mem_freeze), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    if_req       = 1'b0;
    if_addr      = 32'd0;
    branch_taken = 1'b0;
    mem_r_en     = 1'b0;
    mem_w_en     = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    sram_rdata   = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    // Reset for two cycles, then check that every output is cleared.
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check_eq("rst_sram_en", 32'(sram_en), 32'd0);
    check_eq("rst_sram_we", 32'(sram_we), 32'd0);
    check_eq("rst_sram_addr", sram_addr, 32'd0);
    check_eq("rst_sram_wdata", sram_wdata, 32'd0);
    check_eq("rst_if_instr", if_instruction, 32'd0);
    check_eq("rst_mem_rdata", mem_rdata, 32'd0);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_mem_ready", 32'(mem_ready), 32'd0);
    check_eq("rst_if_freeze", 32'(if_freeze), 32'd0);
    check_eq("rst_mem_freeze", 32'(mem_freeze), 32'd0);
    next_cycle();

    // Single fetch of 0x4.
    for (int c = 0; c <= 5; c++) begin
      idle_inputs();
      if (c <= 4) begin
        if_req  = 1'b1;
        if_addr = 32'h4;
      end
      sram_rdata = 32'hE3A01005;
      #1;
      check_eq("fetch_en", 32'(sram_en), 32'((c >= 1) && (c <= 3)));
      check_eq("fetch_we", 32'(sram_we), 32'd0);
      check_eq("fetch_valid", 32'(if_valid), 32'(c == 4));
      check_eq("fetch_freeze", 32'(if_freeze), 32'(c <= 3));
      if ((c >= 1) && (c <= 3)) check_eq("fetch_addr", sram_addr, 32'h4);
      if (c == 4) check_eq("fetch_instr", if_instruction, 32'hE3A01005);
      next_cycle();
    end

    // Store 0xDEADBEEF to 0x400, then load 0x400.
    for (int c = 0; c <= 10; c++) begin
      idle_inputs();
      if (c <= 4) begin
        mem_w_en  = 1'b1;
        mem_addr  = 32'h400;
        mem_wdata = 32'hDEADBEEF;
      end else if (c <= 9) begin
        mem_r_en   = 1'b1;
        mem_addr   = 32'h400;
        sram_rdata = 32'hDEADBEEF;
      end
      #1;
      check_eq("st_ld_en", 32'(sram_en), 32'(((c >= 1) && (c <= 3)) || ((c >= 6) && (c <= 8))));
      check_eq("st_ld_we", 32'(sram_we), 32'((c >= 1) && (c <= 3)));
      check_eq("st_ld_ready", 32'(mem_ready), 32'((c == 4) || (c == 9)));
      check_eq("st_ld_freeze", 32'(mem_freeze), 32'((c <= 3) || ((c >= 5) && (c <= 8))));
      if ((c >= 1) && (c <= 3)) begin
        check_eq("st_addr", sram_addr, 32'h400);
        check_eq("st_wdata", sram_wdata, 32'hDEADBEEF);
      end
      if (c == 4) check_eq("st_rdata_unchanged", mem_rdata, 32'd0);
      if (c == 9) check_eq("ld_rdata", mem_rdata, 32'hDEADBEEF);
      next_cycle();
    end

    // Fetch and load requested together: MEM is served first.
    for (int c = 0; c <= 10; c++) begin
      idle_inputs();
      if (c <= 4) begin
        mem_r_en = 1'b1;
        mem_addr = 32'h800;
      end
      if (c <= 9) begin
        if_req  = 1'b1;
        if_addr = 32'h10;
      end
      sram_rdata = (c <= 4) ? 32'h11111111 : 32'h22222222;
      #1;
      check_eq("prio_ready", 32'(mem_ready), 32'(c == 4));
      check_eq("prio_valid", 32'(if_valid), 32'(c == 9));
      check_eq("prio_if_freeze", 32'(if_freeze), 32'(c <= 8));
      check_eq("prio_mem_freeze", 32'(mem_freeze), 32'(c <= 3));
      if ((c >= 1) && (c <= 3)) check_eq("prio_mem_addr", sram_addr, 32'h800);
      if ((c >= 6) && (c <= 8)) check_eq("prio_if_addr", sram_addr, 32'h10);
      if (c == 4) check_eq("prio_rdata", mem_rdata, 32'h11111111);
      if (c == 9) check_eq("prio_instr", if_instruction, 32'h22222222);
      next_cycle();
    end

    // Branch in cycle 2 cancels the fetch of 0x20; the target 0x100 is fetched from cycle 3.
    for (int c = 0; c <= 8; c++) begin
      idle_inputs();
      if (c <= 2) begin
        if_req  = 1'b1;
        if_addr = 32'h20;
      end else if (c <= 7) begin
        if_req  = 1'b1;
        if_addr = 32'h100;
      end
      branch_taken = (c == 2);
      sram_rdata   = 32'h33333333;
      #1;
      check_eq("br_en", 32'(sram_en), 32'((c == 1) || (c == 2) || ((c >= 4) && (c <= 6))));
      check_eq("br_valid", 32'(if_valid), 32'(c == 7));
      check_eq("br_freeze", 32'(if_freeze), 32'(c <= 6));
      if ((c >= 4) && (c <= 6)) check_eq("br_addr", sram_addr, 32'h100);
      if (c == 7) check_eq("br_instr", if_instruction, 32'h33333333);
      next_cycle();
    end

    // Reset in cycle 2 of a load abandons it without a ready pulse.
    for (int c = 0; c <= 5; c++) begin
      idle_inputs();
      rst = (c == 2);
      if (c <= 2) begin
        mem_r_en = 1'b1;
        mem_addr = 32'h40;
      end
      sram_rdata = 32'h44444444;
      #1;
      check_eq("rmid_en", 32'(sram_en), 32'((c == 1) || (c == 2)));
      check_eq("rmid_ready", 32'(mem_ready), 32'd0);
      if (c == 3) begin
        check_eq("rmid_addr", sram_addr, 32'd0);
        check_eq("rmid_rdata", mem_rdata, 32'd0);
        check_eq("rmid_instr", if_instruction, 32'd0);
      end
      next_cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
